// File: rtl/entry_reg_pkg.sv
// entry_reg_pkg -- shared constants and helpers for the entry register bank.
//   DEFAULT_WIDTH / DEFAULT_DEPTH : default digit width and slot count
//   ZERO_DIGIT                    : value held by an unwritten or cleared slot
//   count_width()                 : bits needed to hold a count of 0..depth
package entry_reg_pkg;

    localparam int DEFAULT_WIDTH = 4;
    localparam int DEFAULT_DEPTH = 4;

    localparam logic [DEFAULT_WIDTH-1:0] ZERO_DIGIT = '0;

    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/entry_reg_bank_if.sv
// entry_reg_bank_if -- digit entry bus between a keypad front end and the bank.
//   enable, rts, enter, din : driven by the master (rts is an active-low clear)
//   dout, count, full,
//   done, ovf               : driven by the bank (slave)
// Handshake: there is no valid/ready pair; enter is a level strobe and each
// low-to-high transition while enable is high is one capture request. The
// bank never back-pressures; a request while full is reported on ovf.
interface entry_reg_bank_if
    import entry_reg_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
);

    localparam int CW = count_width(DEPTH);

    logic                   enable;
    logic                   rts;
    logic                   enter;
    logic [WIDTH-1:0]       din;
    logic [WIDTH*DEPTH-1:0] dout;
    logic [CW-1:0]          count;
    logic                   full;
    logic                   done;
    logic                   ovf;

    modport master (
        output enable, rts, enter, din,
        input  dout, count, full, done, ovf
    );

    modport slave (
        input  enable, rts, enter, din,
        output dout, count, full, done, ovf
    );

endinterface

// File: rtl/entry_reg_bank_rise_detect.sv
// rise_detect -- falling-edge-clocked rising-edge detector for the enter strobe.
//   clk, rst : clock (state on falling edge), async active-high reset
//   enable   : qualifies the pulse only; the history register always tracks in
//   in       : level input
//   pulse    : combinational, high while in=1, previous sample=0 and enable=1
// The history register resets to 1 so a level held through reset is not seen
// as a fresh press.
module rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic in,
    output logic pulse
);

    logic in_q;

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            in_q <= 1'b1;
        end else begin
            in_q <= in;
        end
    end

    assign pulse = enable & in & ~in_q;

endmodule

// File: rtl/entry_reg_bank.sv
// entry_reg_bank -- bank of DEPTH digit slots filled in arrival order.
//   clk  : clock, all state changes on the falling edge
//   rst  : asynchronous active-high reset
//   bus  : entry_reg_bank_if.slave (enable, rts, enter, din -> dout, count,
//          full, done, ovf)
// Optional feature: define ENTRY_REG_BANK_WRAP_EN to make a capture while full
// shift the oldest digit out and append the new one (done and ovf both pulse).
// Without it, a capture while full is dropped and only ovf pulses.
module entry_reg_bank
    import entry_reg_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic            clk,
    input  logic            rst,
    entry_reg_bank_if.slave bus
);

    localparam int              CW         = count_width(DEPTH);
    localparam logic [CW-1:0]   FULL_COUNT = CW'(DEPTH);
    localparam logic [WIDTH-1:0] ZERO       = WIDTH'(ZERO_DIGIT);

    logic [WIDTH-1:0] slots [DEPTH];
    logic [CW-1:0]    count_r;
    logic             done_r;
    logic             ovf_r;
    logic             capture;
    logic             clear;
    logic             is_full;

    rise_detect u_rise_detect (
        .clk    (clk),
        .rst    (rst),
        .enable (bus.enable),
        .in     (bus.enter),
        .pulse  (capture)
    );

    // Clear outranks a coincident capture; with enable low neither fires,
    // which freezes the bank and lets done/ovf fall back to 0.
    assign clear   = bus.enable & ~bus.rts;
    assign is_full = (count_r == FULL_COUNT);

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                slots[i] <= ZERO;
            end
            count_r <= '0;
            done_r  <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            ovf_r  <= 1'b0;
            if (clear) begin
                for (int i = 0; i < DEPTH; i++) begin
                    slots[i] <= ZERO;
                end
                count_r <= '0;
            end else if (capture) begin
                if (!is_full) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        if (count_r == CW'(i)) begin
                            slots[i] <= bus.din;
                        end
                    end
                    count_r <= count_r + 1'b1;
                    done_r  <= (count_r == FULL_COUNT - 1'b1);
                end else begin
                    ovf_r <= 1'b1;
`ifdef ENTRY_REG_BANK_WRAP_EN
                    for (int i = 0; i < DEPTH - 1; i++) begin
                        slots[i] <= slots[i+1];
                    end
                    slots[DEPTH-1] <= bus.din;
                    done_r         <= 1'b1;
`else
                    done_r <= 1'b0;
`endif
                end
            end
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_dout
        assign bus.dout[g*WIDTH +: WIDTH] = slots[g];
    end

    assign bus.count = count_r;
    assign bus.full  = is_full;
    assign bus.done  = done_r;
    assign bus.ovf   = ovf_r;

endmodule

// File: tb/tb_entry_reg_bank.sv
// tb_entry_reg_bank -- self-checking bench for entry_reg_bank.
// A digit queue models the bank; every falling edge the model consumes the
// driven inputs and pushes the expected outputs, and a monitor compares them
// on the following rising edge.
module tb_entry_reg_bank;

    localparam int WIDTH = 4;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int WD    = WIDTH * DEPTH;
    localparam int SW    = WD + CW + 3;

    // clock / reset
    logic clk;
    logic rst;
    logic clk_on;

    initial begin
        clk = 1'b0;
        wait (clk_on);
        forever #5 clk = ~clk;
    end

    entry_reg_bank_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    entry_reg_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // scoreboard
    logic [SW-1:0] exp_q[$];
    int            n_total;
    int            n_pass;

    // reference model: the bank is an ordered list of digits
    int unsigned m_digits[$];
    bit          m_prev_enter;
    bit          m_done;
    bit          m_ovf;

    function automatic logic [SW-1:0] model_out();
        logic [WD-1:0] acc;
        acc = '0;
        foreach (m_digits[i]) acc = acc | (WD'(m_digits[i]) << (i * WIDTH));
        return {acc, CW'(m_digits.size()), m_digits.size() == DEPTH, m_done, m_ovf};
    endfunction

    task automatic model_reset();
        m_digits.delete();
        m_prev_enter = 1'b1;
        m_done       = 1'b0;
        m_ovf        = 1'b0;
    endtask

    task automatic model_edge(input bit en, input bit rts_n, input bit ent,
                              input logic [WIDTH-1:0] d);
        bit req;
        req          = en && ent && !m_prev_enter;
        m_prev_enter = ent;
        m_done       = 1'b0;
        m_ovf        = 1'b0;
        if (en && !rts_n) begin
            m_digits.delete();
        end else if (req) begin
            if (m_digits.size() < DEPTH) begin
                m_digits.push_back(int'(d));
                m_done = (m_digits.size() == DEPTH);
            end else begin
                m_ovf = 1'b1;
`ifdef ENTRY_REG_BANK_WRAP_EN
                void'(m_digits.pop_front());
                m_digits.push_back(int'(d));
                m_done = 1'b1;
`endif
            end
        end
    endtask

    function automatic logic [SW-1:0] dut_out();
        return {bus.dout, bus.count, bus.full, bus.done, bus.ovf};
    endfunction

    task automatic check(input string name, input logic [SW-1:0] act,
                         input logic [SW-1:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got dout=%h count=%0d full=%b done=%b ovf=%b, expected dout=%h count=%0d full=%b done=%b ovf=%b",
                     name, act[SW-1 -: WD], act[CW+2:3], act[2], act[1], act[0],
                     exp[SW-1 -: WD], exp[CW+2:3], exp[2], exp[1], exp[0]);
        end
    endtask

    // model runs on every active edge using the bench's own drive values
    always @(negedge clk) begin
        if (!rst) begin
            model_edge(bus.enable, bus.rts, bus.enter, bus.din);
            exp_q.push_back(model_out());
        end
    end

    // monitor: compare away from the active edge
    initial begin
        forever begin
            @(posedge clk);
            if (exp_q.size() > 0) begin
                check("edge", dut_out(), exp_q.pop_front());
            end
        end
    end

    // driver
    task automatic step(input bit en, input bit rts_n, input bit ent,
                        input logic [WIDTH-1:0] d);
        @(posedge clk);
        bus.enable = en;
        bus.rts    = rts_n;
        bus.enter  = ent;
        bus.din    = d;
    endtask

    task automatic press(input logic [WIDTH-1:0] d);
        step(1'b1, 1'b1, 1'b1, d);
        step(1'b1, 1'b1, 1'b0, d);
    endtask

    initial begin
        n_total    = 0;
        n_pass     = 0;
        clk_on     = 1'b0;
        rst        = 1'b0;
        bus.enable = 1'b0;
        bus.rts    = 1'b1;
        bus.enter  = 1'b0;
        bus.din    = '0;
        model_reset();

        // reset with no clock running takes effect immediately
        #2 rst = 1'b1;
        #1 check("reset_async", dut_out(), {SW{1'b0}});
        #2 rst = 1'b0;
        clk_on = 1'b1;

        // fill 3,5,7,9 then overflow with 2
        press(4'd3);
        press(4'd5);
        press(4'd7);
        press(4'd9);
        press(4'd2);

        // clear, then held enter yields a single capture
        step(1'b1, 1'b0, 1'b0, 4'd0);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b1, 4'd6);
        step(1'b1, 1'b1, 1'b0, 4'd6);

        // clear wins over a coincident enter rise with count=2
        press(4'd1);
        step(1'b1, 1'b0, 1'b1, 4'd8);
        step(1'b1, 1'b1, 1'b0, 4'd8);

        // disabled: enter toggling and rts low change nothing
        press(4'd4);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, i[0], 4'd11);
        // re-enable with enter already high: no capture until a new rise
        step(1'b1, 1'b1, 1'b1, 4'd12);
        step(1'b1, 1'b1, 1'b1, 4'd12);
        press(4'd13);

        // reset mid-press: enter held through reset is not a new press
        step(1'b1, 1'b1, 1'b1, 4'd14);
        @(posedge clk);
        #1 rst = 1'b1;
        model_reset();
        #1 check("reset_mid", dut_out(), {SW{1'b0}});
        #1 rst = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 4'd14);
        press(4'd10);

        // randomized traffic
        for (int i = 0; i < 300; i++) begin
            step($urandom_range(0, 9) != 0, $urandom_range(0, 15) != 0,
                 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
        end

        step(1'b1, 1'b1, 1'b0, 4'd0);
        repeat (3) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/entry_reg_bank.md
ENTRY_REG_BANK -- requirements
Module: entry_reg_bank

Interface
REQ-001 Parameter WIDTH, default 4, bits per entered digit (>=1).
REQ-002 Parameter DEPTH, default 4, number of digit slots (>=2).
REQ-003 clk  input  1  system clock; all state updates on the falling edge.
REQ-004 rst  input  1  reset; one clock, asynchronous and active-high.
REQ-005 enable  input  1  block enable; rts and enter are ignored while low.
REQ-006 rts  input  1  synchronous clear, active-low, qualified by enable.
REQ-007 enter  input  1  debounced level strobe; one capture per low-to-high transition.
REQ-008 din  input  WIDTH  digit value to capture.
REQ-009 dout  output  WIDTH*DEPTH  packed slots, slot i at bits [i*WIDTH +: WIDTH], slot 0 oldest.
REQ-010 count  output  clog2(DEPTH+1)  number of valid slots.
REQ-011 full  output  1  high when count == DEPTH.
REQ-012 done  output  1  one-cycle pulse when a capture makes count reach DEPTH.
REQ-013 ovf  output  1  one-cycle pulse when a capture is requested while full.

Function
REQ-014 enter_q SHALL register enter on every falling edge, regardless of enable.
REQ-015 A capture request is enable & enter & ~enter_q at a falling edge; a held enter SHALL yield exactly one request.
REQ-016 Priority per edge: rst, then clear (enable=1, rts=0), then capture, then hold.
REQ-017 Clear SHALL zero all slots and count and deassert done/ovf; a coincident capture request SHALL be discarded.
REQ-018 Capture while not full: slot[count] <= din and count <= count+1 on the same edge (zero added latency).
REQ-019 done SHALL pulse high on the edge where count becomes DEPTH and SHALL be low on the following edge unless re-asserted.
REQ-020 Capture while full: behaviour per REQ-026/027; ovf SHALL pulse for one cycle in both cases.
REQ-021 Unwritten slots SHALL read zero; full SHALL be combinational from count.
REQ-022 enable low SHALL freeze slots, count, and full, and force done=ovf=0 on the next edge.
REQ-023 count SHALL never exceed DEPTH or wrap to zero except by rst or clear.

Reset
REQ-024 rst high SHALL immediately, without a clock, set all slots to 0, count 0, done 0, ovf 0, and enter_q 1. With enter_q at 1, an enter held through reset is not treated as a new press.
REQ-025 After rst deasserts mid-press, a capture SHALL require enter to go low and then high again.

Configuration
REQ-026 With ENTRY_REG_BANK_WRAP_EN defined, a capture while full SHALL shift slots down by one (slot 0 dropped), write din to slot DEPTH-1, keep count=DEPTH, and pulse done and ovf.
REQ-027 Without ENTRY_REG_BANK_WRAP_EN, a capture while full SHALL leave all slots unchanged, pulse ovf only, and leave done low.

Structure
REQ-028 Package entry_reg_pkg SHALL hold the default WIDTH/DEPTH constants, the zero-digit constant, and the count-width function.
REQ-029 The enter edge detector SHALL be a sub-module named rise_detect (clk, rst, enable, in, pulse), instanced once.

Verification
REQ-030 Reset: assert rst with no clock running -> dout=0, count=0, full=0, done=0, ovf=0 immediately.
REQ-031 Fill: defaults, enter pulses with din=3,5,7,9 -> dout=16'h9753, count=4, full=1, done high exactly on the fourth capture edge.
REQ-032 Held enter: enter held high for 10 cycles with din=6 -> one capture, count=1, slot0=6.
REQ-033 Clear priority: enable=1, rts=0, and an enter rise on the same edge, with count=2 -> count=0, dout=0, no capture.
REQ-034 Overflow: from the REQ-031 state, enter with din=2 -> with WRAP_EN dout=16'h2975, done=1, ovf=1; without WRAP_EN dout=16'h9753, done=0, ovf=1.
REQ-035 Disabled: enable=0, with enter toggling and rts=0 -> all outputs unchanged; then enable=1 with enter already high -> no capture until a new rise.
